// File: rtl/input_script_player.sv
// Scripted key-matrix stimulus player: replays timed button masks, paced by retired
// instructions, onto the CPU's S/K matrix. Define INPUT_SCRIPT_PRIORITY_SCAN_EN for lowest-row-wins scanning.
module input_script_player #(
  parameter  int ROWS    = 8,
  parameter  int COLS    = 4,
  parameter  int EVENTS  = 16,
  parameter  int DELTA_W = 24,
  localparam int BTN     = ROWS * COLS,
  localparam int AW      = $clog2(EVENTS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               step,
  input  logic               start,
  input  logic               script_we,
  input  logic [AW-1:0]      script_addr,
  input  logic [DELTA_W-1:0] script_delta,
  input  logic [BTN-1:0]     script_mask,
  input  logic [AW:0]        script_len,
  input  logic [BTN-1:0]     manual_buttons,
  input  logic [ROWS-1:0]    shifter_s,
  output logic [COLS-1:0]    input_k,
  output logic [BTN-1:0]     buttons,
  output logic               busy,
  output logic               done,
  output logic [31:0]        step_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_APPLY, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [AW:0]          idx_q, idx_d;
  logic [AW:0]          len_q, len_clamped;
  logic [DELTA_W-1:0]   cnt_q, cnt_inc;
  logic [BTN-1:0]       buttons_q, eff;
  logic [31:0]          step_count_q;
  logic [DELTA_W+BTN-1:0] mem [EVENTS];
  logic [DELTA_W+BTN-1:0] rd_q;
  logic [DELTA_W-1:0]   rd_delta;
  logic [BTN-1:0]       rd_mask;
  logic                 qstep, hit;

  assign qstep       = step & clk_en;
  assign len_clamped = (script_len > (AW+1)'(EVENTS)) ? (AW+1)'(EVENTS) : script_len;
  assign {rd_delta, rd_mask} = rd_q;
  assign cnt_inc     = cnt_q + DELTA_W'(1);
  // The final qualifying step is matched as it arrives, so the mask lands one cycle later.
  assign hit         = (cnt_q == rd_delta) || (qstep && (cnt_inc == rd_delta));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (start) begin
      idx_d   = '0;
      state_d = (len_clamped == '0) ? S_DONE : S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  state_d = (rd_delta == '0) ? S_APPLY : S_WAIT;
        S_WAIT:  if (hit) state_d = S_APPLY;
        S_APPLY: begin
          idx_d   = idx_q + (AW+1)'(1);
          state_d = (idx_d == len_q) ? S_DONE : S_LOAD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_LOAD, S_WAIT, S_APPLY: busy = 1'b1;
      S_DONE:                  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      buttons_q    <= '0;
      step_count_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (start) begin
        len_q        <= len_clamped;
        cnt_q        <= '0;
        buttons_q    <= '0;
        step_count_q <= '0;
      end else begin
        if (qstep && (busy || done) && (step_count_q != '1))
          step_count_q <= step_count_q + 32'd1;
        if (state_q == S_LOAD)
          cnt_q <= '0;
        else if (state_q == S_WAIT && qstep)
          cnt_q <= cnt_inc;
        if (state_q == S_APPLY)
          buttons_q <= rd_mask;
      end
    end
  end

  // NOTE: the script RAM and its read register are deliberately left unreset so they map to block RAM.
  // The read address follows idx_d, so the current event is already on rd_q during LOAD.
  always_ff @(posedge clk) begin
    if (script_we && !busy)
      mem[script_addr] <= {script_delta, script_mask};
    rd_q <= mem[idx_d[AW-1:0]];
  end

  assign buttons    = buttons_q;
  assign step_count = step_count_q;
  assign eff        = buttons_q | manual_buttons;

`ifdef INPUT_SCRIPT_PRIORITY_SCAN_EN
  logic found;
  always_comb begin
    input_k = '0;
    found   = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (shifter_s[r] && !found) begin
        input_k = eff[r*COLS +: COLS];
        found   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    input_k = '0;
    for (int r = 0; r < ROWS; r++)
      if (shifter_s[r]) input_k = input_k | eff[r*COLS +: COLS];
  end
`endif

endmodule

// File: tb/tb_input_script_player.sv
// Self-checking bench for input_script_player: directed multi-cycle sequences, a scan
// vector table and randomized scripts checked against an event-timeline model.
module tb_input_script_player;
  localparam int ROWS = 8, COLS = 4, EVENTS = 16, DELTA_W = 24, BTN = 32, AW = 4;
  localparam int NCYC = 64;

  logic               clk = 1'b0;
  logic               reset_n, clk_en, step, start, script_we;
  logic [AW-1:0]      script_addr;
  logic [DELTA_W-1:0] script_delta;
  logic [BTN-1:0]     script_mask, manual_buttons, buttons;
  logic [AW:0]        script_len;
  logic [ROWS-1:0]    shifter_s;
  logic [COLS-1:0]    input_k;
  logic               busy, done;
  logic [31:0]        step_count;
  int                 n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  input_script_player #(.ROWS(ROWS), .COLS(COLS), .EVENTS(EVENTS), .DELTA_W(DELTA_W)) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .step(step), .start(start),
    .script_we(script_we), .script_addr(script_addr), .script_delta(script_delta),
    .script_mask(script_mask), .script_len(script_len), .manual_buttons(manual_buttons),
    .shifter_s(shifter_s), .input_k(input_k), .buttons(buttons), .busy(busy),
    .done(done), .step_count(step_count)
  );

  typedef struct {
    logic [BTN-1:0]  manual;
    logic [ROWS-1:0] s;
    logic [COLS-1:0] exp_or;
    logic [COLS-1:0] exp_pri;
  } scan_vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic write_ev(input int addr, input int delta, input logic [BTN-1:0] mask);
    script_we = 1'b1; script_addr = AW'(addr); script_delta = DELTA_W'(delta); script_mask = mask;
    tick(1);
    script_we = 1'b0;
  endtask

  task automatic pulse_start(input int len);
    script_len = (AW+1)'(len); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic step_pulse(input int gap);
    step = 1'b1; tick(1); step = 1'b0; tick(gap - 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (!done && i < budget) begin tick(1); i++; end
    check(name, done, 1'b1);
  endtask

  // Button b sits at row b/COLS, column b%COLS; a row is live if its strobe selects it.
  function automatic logic [COLS-1:0] ref_k(input logic [BTN-1:0] e, input logic [ROWS-1:0] s);
    logic [COLS-1:0] k = '0;
`ifdef INPUT_SCRIPT_PRIORITY_SCAN_EN
    int low = -1;
    for (int r = ROWS - 1; r >= 0; r--) if (s[r]) low = r;
    for (int b = 0; b < BTN; b++) if (e[b] && (b / COLS == low)) k[b % COLS] = 1'b1;
`else
    for (int b = 0; b < BTN; b++) if (e[b] && s[b / COLS]) k[b % COLS] = 1'b1;
`endif
    return k;
  endfunction

  task automatic random_trial(input int trial);
    int d [4];
    logic [BTN-1:0] m [4];
    bit st [NCYC];
    bit en [NCYC];
    int a_cyc [4];
    int len, l, cnt;
    logic [BTN-1:0] exp_b;
    logic exp_done;
    logic [31:0] sc;
    logic [69:0] act_v, exp_v;
    pulse_start(0);
    len = $urandom_range(1, 4);
    for (int k = 0; k < 4; k++) begin
      d[k] = $urandom_range(0, 4);
      m[k] = $urandom;
      write_ev(k, d[k], m[k]);
    end
    for (int c = 0; c < NCYC; c++) begin
      st[c] = ($urandom_range(0, 1) == 1);
      en[c] = ($urandom_range(0, 3) != 0);
    end
    // Timeline: event k presented in cycle l, applied in cycle a_cyc[k], visible from a_cyc[k]+1.
    l = 0;
    for (int k = 0; k < len; k++) begin
      if (d[k] == 0) a_cyc[k] = l + 1;
      else begin
        a_cyc[k] = 1 << 20;
        cnt = 0;
        for (int t = l + 1; t < NCYC; t++) begin
          if (st[t] && en[t]) begin
            cnt++;
            if (cnt == d[k]) begin a_cyc[k] = t + 1; break; end
          end
        end
      end
      l = a_cyc[k] + 1;
    end
    pulse_start(len);
    sc = '0;
    for (int c = 0; c < NCYC; c++) begin
      step = st[c]; clk_en = en[c];
      shifter_s = ROWS'($urandom); manual_buttons = $urandom & 32'h0F0F_0F0F;
      #1;
      exp_b = '0;
      for (int k = 0; k < len; k++) if (a_cyc[k] + 1 <= c) exp_b = m[k];
      exp_done = (a_cyc[len-1] + 1 <= c);
      act_v = {buttons, busy, done, step_count, input_k};
      exp_v = {exp_b, ~exp_done, exp_done, sc, ref_k(exp_b | manual_buttons, shifter_s)};
      check($sformatf("rand%0d_cyc%0d", trial, c), act_v, exp_v);
      if (st[c] && en[c]) sc++;
      tick(1);
    end
    step = 1'b0; clk_en = 1'b1; shifter_s = '0; manual_buttons = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    scan_vec_t tbl [6];
    tbl[0] = '{32'h0000_0042, 8'h03, 4'h6, 4'h2};
    tbl[1] = '{32'h0000_0040, 8'h02, 4'h4, 4'h4};
    tbl[2] = '{32'h0000_0040, 8'h00, 4'h0, 4'h0};
    tbl[3] = '{32'hF000_0000, 8'h80, 4'hF, 4'hF};
    tbl[4] = '{32'h0000_0100, 8'h05, 4'h1, 4'h0};
    tbl[5] = '{32'h0000_0021, 8'h02, 4'h2, 4'h2};

    reset_n = 1'b0; clk_en = 1'b1; step = 1'b0; start = 1'b0; script_we = 1'b0;
    script_addr = '0; script_delta = '0; script_mask = '0; script_len = '0;
    manual_buttons = '0; shifter_s = '0;
    #3;
    check("reset_outputs", {buttons, busy, done, step_count, input_k}, 70'd0);
    @(negedge clk); reset_n = 1'b1;
    tick(1);
    check("idle_after_reset", {busy, done}, 2'b00);

    // Scan decode with an empty script: only live buttons drive eff.
    for (int i = 0; i < 6; i++) begin
      manual_buttons = tbl[i].manual; shifter_s = tbl[i].s;
      #1;
`ifdef INPUT_SCRIPT_PRIORITY_SCAN_EN
      check($sformatf("scan_vec%0d", i), input_k, tbl[i].exp_pri);
`else
      check($sformatf("scan_vec%0d", i), input_k, tbl[i].exp_or);
`endif
    end
    manual_buttons = '0; shifter_s = '0;
    tick(1);

    // Two timed events paced by a step every 4 clocks.
    write_ev(0, 5, 32'h200);
    write_ev(1, 3, 32'h0);
    pulse_start(2);
    tick(1);
    repeat (4) step_pulse(4);
    step = 1'b1; tick(1); step = 1'b0;
    check("ev0_not_early", buttons, 32'h0);
    check("ev0_busy", busy, 1'b1);
    tick(1);
    check("ev0_applied", buttons, 32'h200);
    shifter_s = 8'h04; #1;
    check("ev0_k_row2", input_k, 4'h2);
    shifter_s = 8'h02; #1;
    check("ev0_k_row1", input_k, 4'h0);
    shifter_s = 8'h00;
    tick(2);
    repeat (2) step_pulse(4);
    step = 1'b1; tick(1); step = 1'b0;
    check("ev1_not_early", buttons, 32'h200);
    tick(1);
    check("ev1_applied", buttons, 32'h0);
    check("ev1_done_busy", {done, busy}, 2'b10);
    check("ev1_step_count", step_count, 32'd8);

    // Back-to-back zero-delta events.
    write_ev(0, 0, 32'h1);
    write_ev(1, 0, 32'h3);
    pulse_start(2);
    check("d0_c0", buttons, 32'h0);
    tick(1); check("d0_c1", buttons, 32'h0);
    tick(1); check("d0_c2", buttons, 32'h1);
    tick(1); check("d0_c3", {buttons, done}, {32'h1, 1'b0});
    tick(1); check("d0_c4", {buttons, done}, {32'h3, 1'b1});

    // Empty script.
    pulse_start(0);
    check("len0_state", {buttons, busy, done}, {32'h0, 1'b0, 1'b1});
    tick(2);
    check("len0_no_busy", busy, 1'b0);

    // Restart during the second event's wait, with a write attempted while busy.
    write_ev(0, 2, 32'h11);
    write_ev(1, 50, 32'h22);
    pulse_start(2);
    tick(1);
    step = 1'b1; tick(2); step = 1'b0;
    tick(1);
    check("rs_ev0", buttons, 32'h11);
    tick(1);
    step = 1'b1; tick(3); step = 1'b0;
    check("rs_count", step_count, 32'd5);
    write_ev(0, 2, 32'hFFFF);
    pulse_start(2);
    check("rs_cleared", {buttons, step_count, busy}, {32'h0, 32'h0, 1'b1});
    tick(1);
    step = 1'b1; tick(2); step = 1'b0;
    tick(1);
    check("rs_replay", buttons, 32'h11);
    step = 1'b1;
    wait_done("rs_finish", 80);
    step = 1'b0;
    check("rs_final", buttons, 32'h22);
    pulse_start(2);
    tick(1);
    step = 1'b1; tick(2); step = 1'b0;
    tick(1);
    check("rs_mem_kept", buttons, 32'h11);
    pulse_start(0);

    // Length above EVENTS plays exactly EVENTS entries.
    for (int i = 0; i < EVENTS; i++) write_ev(i, 0, 32'(i + 1));
    pulse_start(31);
    tick(31);
    check("clamp_not_done", done, 1'b0);
    tick(1);
    check("clamp_done", {done, buttons}, {1'b1, 32'd16});

    // Asynchronous reset in the middle of a wait.
    write_ev(0, 1, 32'h40);
    write_ev(1, 100, 32'h0);
    pulse_start(2);
    tick(1);
    step = 1'b1; tick(1); step = 1'b0;
    tick(2);
    shifter_s = 8'h02; #1;
    check("mid_wait_state", {buttons, busy, input_k}, {32'h40, 1'b1, 4'h4});
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset", {buttons, busy, done, step_count, input_k}, 70'd0);
    shifter_s = '0;
    @(negedge clk); reset_n = 1'b1;
    tick(1);
    pulse_start(2);
    tick(1);
    step = 1'b1; tick(1); step = 1'b0;
    tick(1);
    check("post_reset_replay", buttons, 32'h40);
    pulse_start(0);

    for (int t = 0; t < 4; t++) random_trial(t);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
